// File: rtl/rr_interval_extractor.sv
// -----------------------------------------------------------------------------
// rr_interval_extractor
// R-peak detector and RR-interval timer. It watches a pre-filtered 8-bit ECG
// stream, picks out R-peaks using a hysteresis threshold pair and a
// refractory window, and reports the spacing between successive peaks as a
// scaled 8-bit RR interval.
// All state advances only on sample_valid strobes. The pulse outputs are
// registered, so each pulse appears one cycle after the strobe that caused it.
// -----------------------------------------------------------------------------
module rr_interval_extractor #(
   parameter logic [7:0]  TH_HI       = 8'd160,
   parameter logic [7:0]  TH_LO       = 8'd96,
   parameter logic [11:0] REFRACT     = 12'd51,
   parameter logic [11:0] MAX_SAMPLES = 12'd768,
   parameter int          RR_SHIFT    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       sample_valid,
   input  logic [7:0] ecg_in,
   output logic [7:0] rr_out,
   output logic       rr_valid,
   output logic       beat,
   output logic       lost
);

   typedef enum logic [1:0] {
      ST_FIRST   = 2'd0,
      ST_REFRACT = 2'd1,
      ST_SEARCH  = 2'd2
   } state_t;

   state_t      state_r,    state_s;
   logic [11:0] cnt_r,      cnt_s;
   logic        armed_r,    armed_s;
   logic [7:0]  rr_out_r,   rr_out_s;
   logic        rr_valid_r, rr_valid_s;
   logic        beat_r,     beat_s;
   logic        lost_r,     lost_s;

   logic [11:0] interval_s;
   logic        crossing_s;

   // Scale an interval down and clamp it to the 8-bit output range.
   function automatic logic [7:0] scale_rr(input logic [11:0] iv);
      logic [11:0] sh;
      sh = iv >> RR_SHIFT;
      if (sh > 12'd255) begin
         return 8'd255;
      end else begin
         return sh[7:0];
      end
   endfunction

   // Strobes since the previous peak, counting the current one; cnt is
   // bounded by MAX_SAMPLES so the increment cannot wrap.
   assign interval_s = cnt_r + 12'd1;
   assign crossing_s = sample_valid & armed_r & (ecg_in >= TH_HI);

   // Next-state, counter, hysteresis flag and output-register computation.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      armed_s    = armed_r;
      rr_out_s   = rr_out_r;
      rr_valid_s = 1'b0;
      beat_s     = 1'b0;
      lost_s     = 1'b0;

      if (!en) begin
         // Disabled: drop the reference peak; rr_out and armed are kept.
         state_s = ST_FIRST;
         cnt_s   = 12'd0;
      end else if (sample_valid) begin
         // Any low sample re-arms; an accepted peak below overrides this.
         if (ecg_in < TH_LO) begin
            armed_s = 1'b1;
         end else begin
            armed_s = armed_r;
         end

         case (state_r)
            ST_FIRST: begin
               cnt_s = 12'd0;
               if (crossing_s) begin
                  beat_s  = 1'b1;
                  armed_s = 1'b0;
                  state_s = ST_REFRACT;
               end else begin
                  state_s = ST_FIRST;
               end
            end
            ST_REFRACT: begin
               // Crossings are ignored here; armed keeps tracking TH_LO.
               cnt_s = interval_s;
               if (interval_s >= REFRACT) begin
                  state_s = ST_SEARCH;
               end else begin
                  state_s = ST_REFRACT;
               end
            end
            ST_SEARCH: begin
               // A crossing on the timeout sample still counts as a beat.
               if (crossing_s) begin
                  beat_s     = 1'b1;
                  rr_valid_s = 1'b1;
                  rr_out_s   = scale_rr(interval_s);
                  armed_s    = 1'b0;
                  cnt_s      = 12'd0;
                  state_s    = ST_REFRACT;
               end else if (interval_s >= MAX_SAMPLES) begin
                  lost_s  = 1'b1;
                  cnt_s   = 12'd0;
                  state_s = ST_FIRST;
               end else begin
                  cnt_s   = interval_s;
                  state_s = ST_SEARCH;
               end
            end
            default: begin
               cnt_s   = 12'd0;
               state_s = ST_FIRST;
            end
         endcase
      end else begin
         // No strobe: everything holds, pulses stay low.
         state_s = state_r;
      end
   end

   // State, counter and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_FIRST;
         cnt_r      <= 12'd0;
         armed_r    <= 1'b0;
         rr_out_r   <= 8'd0;
         rr_valid_r <= 1'b0;
         beat_r     <= 1'b0;
         lost_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         armed_r    <= armed_s;
         rr_out_r   <= rr_out_s;
         rr_valid_r <= rr_valid_s;
         beat_r     <= beat_s;
         lost_r     <= lost_s;
      end
   end

   assign rr_out   = rr_out_r;
   assign rr_valid = rr_valid_r;
   assign beat     = beat_r;
   assign lost     = lost_r;

endmodule

// File: tb/tb_rr_interval_extractor.sv
// -----------------------------------------------------------------------------
// tb_rr_interval_extractor
// Directed scenarios plus a randomized run, all checked against a reference
// model that tracks peaks by absolute strobe index rather than by state.
// -----------------------------------------------------------------------------
module tb_rr_interval_extractor;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       sample_valid;
   logic [7:0] ecg_in;
   logic [7:0] rr_out;
   logic       rr_valid;
   logic       beat;
   logic       lost;

   int n_cmp;
   int n_err;

   // reference model state
   bit         m_have_ref;
   bit         m_armed;
   int         m_idx;
   int         m_ref_idx;
   logic [7:0] exp_rr;
   logic       exp_beat;
   logic       exp_rrv;
   logic       exp_lost;

   rr_interval_extractor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sample_valid (sample_valid),
      .ecg_in       (ecg_in),
      .rr_out       (rr_out),
      .rr_valid     (rr_valid),
      .beat         (beat),
      .lost         (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a peak is accepted when armed, at/above 160, and either no
   // reference exists or more than 51 strobes have passed since it.
   task automatic model_sample(input logic [7:0] x);
      int  since;
      bit  acc;
      int  q;
      exp_beat = 1'b0;
      exp_rrv  = 1'b0;
      exp_lost = 1'b0;
      since = m_idx - m_ref_idx;
      acc = m_armed && (x >= 8'd160) && (!m_have_ref || since > 51);
      if (acc) begin
         exp_beat = 1'b1;
         if (m_have_ref) begin
            exp_rrv = 1'b1;
            q = since / 4;
            exp_rr = (q > 255) ? 8'd255 : 8'(q);
         end
         m_have_ref = 1'b1;
         m_ref_idx  = m_idx;
         m_armed    = 1'b0;
      end else if (m_have_ref && since >= 768) begin
         exp_lost   = 1'b1;
         m_have_ref = 1'b0;
      end
      if (x < 8'd96) m_armed = 1'b1;
      m_idx++;
   endtask

   // Drive one strobe after `gap` idle cycles; outputs are valid on return.
   task automatic step(input logic [7:0] x, input int gap);
      repeat (gap) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      @(negedge clk);
      sample_valid = 1'b1;
      ecg_in       = x;
      @(posedge clk);
      #1;
      model_sample(x);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_beat = 1'b0;
      exp_rrv  = 1'b0;
      exp_lost = 1'b0;
   endtask

   // Assert reset (outputs settle asynchronously); leaves rst_n low.
   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      en           = 1'b1;
      rst_n        = 1'b0;
      #2;
      m_have_ref = 1'b0;
      m_armed    = 1'b0;
      m_idx      = 0;
      m_ref_idx  = 0;
      exp_rr     = 8'd0;
      exp_beat   = 1'b0;
      exp_rrv    = 1'b0;
      exp_lost   = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({beat, rr_valid, lost, rr_out} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_state got=%h exp=000", {beat, rr_valid, lost, rr_out});
      end
      release_reset();
      for (int i = 0; i < 10; i++) begin
         step(8'd50, 0);
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL reset_low i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      step(8'd200, 0);
      n_cmp++;
      if ({beat, rr_valid, lost} !== 3'b100) begin
         n_err++;
         $display("FAIL first_peak got=%b exp=100", {beat, rr_valid, lost});
      end
   endtask

   task automatic test_interval();
      do_reset();
      release_reset();
      step(8'd50, 0);
      for (int i = 0; i <= 200; i++) begin
         step((i == 0 || i == 200) ? 8'd200 : 8'd50, 0);
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL interval i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if (rr_valid !== 1'b1 || rr_out !== 8'd50) begin
         n_err++;
         $display("FAIL interval_200 got rr_valid=%b rr_out=%0d exp 1/50", rr_valid, rr_out);
      end
   endtask

   task automatic test_spurious();
      int beats;
      int rrvs;
      beats = 0;
      rrvs  = 0;
      do_reset();
      release_reset();
      step(8'd50, 0);
      for (int i = 0; i <= 180; i++) begin
         step((i == 0 || i == 30 || i == 180) ? 8'd200 : 8'd50, 0);
         if (beat === 1'b1) beats++;
         if (rr_valid === 1'b1) rrvs++;
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL spurious i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if (beats != 2 || rrvs != 1 || rr_out !== 8'd45) begin
         n_err++;
         $display("FAIL spurious_sum beats=%0d rrv=%0d rr_out=%0d exp 2/1/45", beats, rrvs, rr_out);
      end
   endtask

   task automatic test_lost();
      do_reset();
      release_reset();
      step(8'd50, 0);
      step(8'd200, 0);
      for (int i = 1; i <= 768; i++) begin
         step(8'd50, 0);
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL lost_run i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if (lost !== 1'b1) begin
         n_err++;
         $display("FAIL lost_pulse got=%b exp=1", lost);
      end
      step(8'd200, 0);
      n_cmp++;
      if ({beat, rr_valid, lost} !== 3'b100) begin
         n_err++;
         $display("FAIL lost_refirst got=%b exp=100", {beat, rr_valid, lost});
      end
      for (int i = 1; i <= 768; i++) begin
         step((i == 768) ? 8'd200 : 8'd50, 0);
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL lost_edge i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if ({beat, rr_valid, lost} !== 3'b110 || rr_out !== 8'd192) begin
         n_err++;
         $display("FAIL lost_768 got=%b rr_out=%0d exp 110/192", {beat, rr_valid, lost}, rr_out);
      end
   endtask

   task automatic test_hysteresis();
      logic [7:0] x;
      do_reset();
      release_reset();
      step(8'd50, 0);
      for (int i = 0; i <= 92; i++) begin
         if (i <= 20)      x = 8'd200;
         else if (i <= 80) x = 8'd120;
         else if (i <= 90) x = 8'd200;
         else if (i == 91) x = 8'd90;
         else              x = 8'd200;
         step(x, 0);
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL hyst i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if ({beat, rr_valid} !== 2'b11 || rr_out !== 8'd23) begin
         n_err++;
         $display("FAIL hyst_peak got=%b rr_out=%0d exp 11/23", {beat, rr_valid}, rr_out);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      release_reset();
      step(8'd50, 1);
      for (int i = 0; i <= 300; i++) begin
         step((i % 100 == 0) ? 8'd200 : 8'd50, int'($urandom_range(1, 5)));
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL gaps i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
      n_cmp++;
      if (rr_out !== 8'd25) begin
         n_err++;
         $display("FAIL gaps_rr got=%0d exp=25", rr_out);
      end
      idle(1);
      n_cmp++;
      if ({beat, rr_valid, lost} !== 3'b000) begin
         n_err++;
         $display("FAIL gaps_idle got=%b exp=000", {beat, rr_valid, lost});
      end
      for (int i = 0; i < 60; i++) step(8'd50, 0);
      do_reset();
      n_cmp++;
      if ({beat, rr_valid, lost, rr_out} !== 11'd0) begin
         n_err++;
         $display("FAIL midreset got=%h exp=000", {beat, rr_valid, lost, rr_out});
      end
      release_reset();
      step(8'd50, 0);
      step(8'd200, 0);
      n_cmp++;
      if ({beat, rr_valid, lost, rr_out} !== {3'b100, 8'd0}) begin
         n_err++;
         $display("FAIL midreset_first got=%h exp=400", {beat, rr_valid, lost, rr_out});
      end
   endtask

   task automatic test_random();
      int r;
      logic [7:0] x;
      do_reset();
      release_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            @(negedge clk);
            en           = 1'b0;
            sample_valid = 1'b1;
            ecg_in       = 8'd220;
            @(posedge clk);
            #1;
            m_have_ref = 1'b0;
            exp_beat   = 1'b0;
            exp_rrv    = 1'b0;
            exp_lost   = 1'b0;
            en         = 1'b1;
         end else begin
            r = int'($urandom_range(0, 19));
            if (r < 12)      x = 8'($urandom_range(0, 95));
            else if (r < 16) x = 8'($urandom_range(96, 159));
            else             x = 8'($urandom_range(160, 255));
            step(x, int'($urandom_range(0, 2)));
         end
         n_cmp++;
         if ({beat, rr_valid, lost, rr_out} !== {exp_beat, exp_rrv, exp_lost, exp_rr}) begin
            n_err++;
            $display("FAIL random i=%0d got=%h exp=%h", i,
                     {beat, rr_valid, lost, rr_out}, {exp_beat, exp_rrv, exp_lost, exp_rr});
         end
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b1;
      en           = 1'b1;
      sample_valid = 1'b0;
      ecg_in       = 8'd0;
      test_reset();
      test_interval();
      test_spurious();
      test_lost();
      test_hysteresis();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
